// File: rtl/nco_phase_feeder.sv
// NCO phase feeder for the pipelined CORDIC rotator: tags each AXIS I/Q beat with a
// 16-bit angle, folding the phase into [-90,+90) deg by negating I/Q when needed.
module nco_phase_feeder #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int C_PHASE_WIDTH          = 32,
  parameter int C_PHI_WIDTH            = 16
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_areset,
  input  logic                              s00_axis_tvalid,
  output logic                              s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                              s00_axis_tlast,
  input  logic [C_PHASE_WIDTH-1:0]          ftw_in,
  input  logic                              ftw_load,
  input  logic                              phase_clear,
  output logic                              m00_axis_tvalid,
  input  logic                              m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                              m00_axis_tlast,
  output logic [3:0]                        m00_axis_tstrb,
  output logic [C_PHI_WIDTH-1:0]            phi_out
);

  localparam int LANE = C_S00_AXIS_TDATA_WIDTH / 2;
  localparam logic [LANE-1:0] LANE_MIN = {1'b1, {(LANE-1){1'b0}}};
  localparam logic [LANE-1:0] LANE_MAX = {1'b0, {(LANE-1){1'b1}}};

  typedef enum logic {ST_RUN, ST_HOLD} state_t;

  // Two's-complement negation that maps the most negative value to the most positive one.
  function automatic logic [LANE-1:0] sat_neg(input logic [LANE-1:0] x);
    sat_neg = (x == LANE_MIN) ? LANE_MAX : (~x + 1'b1);
  endfunction

  state_t                            state_q, state_d;
  logic                              s_ready_q, s_ready_d;
  logic [C_PHASE_WIDTH-1:0]          acc_q, acc_d;
  logic [C_PHASE_WIDTH-1:0]          ftw_q, ftw_d;
  logic [C_PHASE_WIDTH-1:0]          pend_q, pend_d;
  logic                              pend_v_q, pend_v_d;
  logic                              out_valid_q, out_valid_d;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                              out_last_q, out_last_d;
  logic [C_PHI_WIDTH-1:0]            out_phi_q, out_phi_d;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                              skid_last_q, skid_last_d;
  logic [C_PHI_WIDTH-1:0]            skid_phi_q, skid_phi_d;

  logic                              accept;
  logic                              fire;
  logic                              fold;
  logic [C_PHI_WIDTH-1:0]            phi_raw;
  logic [C_PHI_WIDTH-1:0]            beat_phi;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] beat_data;

  // Angles in the second and third quadrants have differing top two bits; the fold
  // subtracts a half circle, which only flips the angle MSB.
  always_comb begin
    accept   = s00_axis_tvalid & s_ready_q;
    fire     = out_valid_q & m00_axis_tready;
    phi_raw  = acc_q[C_PHASE_WIDTH-1 -: C_PHI_WIDTH];
    fold     = phi_raw[C_PHI_WIDTH-1] ^ phi_raw[C_PHI_WIDTH-2];
    beat_phi = phi_raw;
    beat_data = s00_axis_tdata;
    if (fold) begin
      beat_phi  = {~phi_raw[C_PHI_WIDTH-1], phi_raw[C_PHI_WIDTH-2:0]};
      beat_data = {sat_neg(s00_axis_tdata[2*LANE-1:LANE]), sat_neg(s00_axis_tdata[LANE-1:0])};
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_phi_d   = out_phi_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    skid_phi_d  = skid_phi_q;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (out_valid_q && !m00_axis_tready) begin
            skid_data_d = beat_data;
            skid_last_d = s00_axis_tlast;
            skid_phi_d  = beat_phi;
            state_d     = ST_HOLD;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = beat_data;
            out_last_d  = s00_axis_tlast;
            out_phi_d   = beat_phi;
          end
        end else if (fire) begin
          out_valid_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (fire) begin
          out_data_d = skid_data_q;
          out_last_d = skid_last_q;
          out_phi_d  = skid_phi_q;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    s_ready_d = (state_d == ST_RUN);
  end

  // A load in the same cycle as the tlast beat is applied immediately at that boundary;
  // the boundary beat itself still advances by the old tuning word.
  always_comb begin
    acc_d    = acc_q;
    ftw_d    = ftw_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (accept) begin
      acc_d = acc_q + ftw_q;
    end
    if (ftw_load) begin
      pend_d   = ftw_in;
      pend_v_d = 1'b1;
    end
    if (accept && s00_axis_tlast && pend_v_d) begin
      ftw_d    = pend_d;
      pend_v_d = 1'b0;
    end
    if (phase_clear) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q     <= ST_RUN;
      s_ready_q   <= 1'b0;
      acc_q       <= '0;
      ftw_q       <= '0;
      pend_q      <= '0;
      pend_v_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_phi_q   <= '0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      skid_phi_q  <= '0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      acc_q       <= acc_d;
      ftw_q       <= ftw_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_phi_q   <= out_phi_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      skid_phi_q  <= skid_phi_d;
    end
  end

  assign s00_axis_tready = s_ready_q;
  assign m00_axis_tvalid = out_valid_q;
  assign m00_axis_tdata  = out_data_q;
  assign m00_axis_tlast  = out_last_q;
  assign m00_axis_tstrb  = 4'hF;
  assign phi_out         = out_phi_q;

endmodule

// File: tb/tb_nco_phase_feeder.sv
// Randomized bench for nco_phase_feeder against a queue-based reference model of the
// phase accumulator, tuning-word boundary rule, quadrant fold and two-deep buffering.
module tb_nco_phase_feeder;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [15:0] phi;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic [31:0] ftw_in = '0;
  logic        ftw_load = 1'b0;
  logic        phase_clear = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_last;
  logic [3:0]  m_strb;
  logic [15:0] phi;

  int checks = 0;
  int failures = 0;

  beat_t       exp_q[$];
  logic [31:0] mdl_acc = '0;
  logic [31:0] mdl_ftw = '0;
  logic [31:0] mdl_pend = '0;
  logic        mdl_pend_v = 1'b0;
  logic        rst_prev = 1'b1;

  nco_phase_feeder dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_tvalid (s_valid),
    .s00_axis_tready (s_ready),
    .s00_axis_tdata  (s_data),
    .s00_axis_tlast  (s_last),
    .ftw_in          (ftw_in),
    .ftw_load        (ftw_load),
    .phase_clear     (phase_clear),
    .m00_axis_tvalid (m_valid),
    .m00_axis_tready (m_ready),
    .m00_axis_tdata  (m_data),
    .m00_axis_tlast  (m_last),
    .m00_axis_tstrb  (m_strb),
    .phi_out         (phi)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Angle = top 16 phase bits; angles in [90,270) deg get I/Q negated (saturating) and 180 deg removed.
  function automatic beat_t expectBeat(input logic [31:0] acc, input logic [31:0] d, input logic l);
    beat_t b;
    int    ang, i_val, q_val;
    ang   = int'(acc >> 16);
    i_val = int'($signed(d[15:0]));
    q_val = int'($signed(d[31:16]));
    if (ang >= 'h4000 && ang <= 'hBFFF) begin
      ang   = (ang + 'h8000) % 'h10000;
      i_val = (-i_val > 32767) ? 32767 : -i_val;
      q_val = (-q_val > 32767) ? 32767 : -q_val;
    end
    b.phi  = 16'(ang);
    b.data = {16'(q_val), 16'(i_val)};
    b.last = l;
    return b;
  endfunction

  // One clock: check what the DUT shows now, drive the next inputs, advance the model to the next edge.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l, input logic ld,
                               input logic [31:0] fw, input logic clr, input logic mr, input logic r);
    logic        acc_s;
    logic [31:0] acc_next;
    @(negedge clk);
    checkOutput("tstrb", 32'(m_strb), 32'hF);
    if (rst_prev) begin
      checkOutput("rst_tready", 32'(s_ready), 32'd0);
      checkOutput("rst_tvalid", 32'(m_valid), 32'd0);
      checkOutput("rst_tlast", 32'(m_last), 32'd0);
      checkOutput("rst_tdata", m_data, 32'd0);
      checkOutput("rst_phi", 32'(phi), 32'd0);
    end else begin
      checkOutput("tready", 32'(s_ready), 32'(exp_q.size() < 2));
      checkOutput("tvalid", 32'(m_valid), 32'(exp_q.size() > 0));
      if (m_valid && exp_q.size() > 0) begin
        checkOutput("tdata", m_data, exp_q[0].data);
        checkOutput("tlast", 32'(m_last), 32'(exp_q[0].last));
        checkOutput("phi", 32'(phi), 32'(exp_q[0].phi));
      end
    end
    s_valid = v; s_data = d; s_last = l; ftw_load = ld; ftw_in = fw;
    phase_clear = clr; m_ready = mr; rst = r;
    if (r) begin
      exp_q.delete();
      mdl_acc = '0; mdl_ftw = '0; mdl_pend = '0; mdl_pend_v = 1'b0;
    end else begin
      acc_s = v && s_ready && !rst_prev;
      if (m_valid && mr && exp_q.size() > 0) void'(exp_q.pop_front());
      acc_next = mdl_acc;
      if (acc_s) begin
        exp_q.push_back(expectBeat(mdl_acc, d, l));
        acc_next = mdl_acc + mdl_ftw;
      end
      if (ld) begin
        mdl_pend = fw; mdl_pend_v = 1'b1;
      end
      if (acc_s && l && mdl_pend_v) begin
        mdl_ftw = mdl_pend; mdl_pend_v = 1'b0;
      end
      mdl_acc = clr ? 32'd0 : acc_next;
    end
    rst_prev = r;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] d;
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Quarter-turn steps with a constant I=1000 beat.
    applyStimulus(1'b1, 32'h0000_03E8, 1'b1, 1'b1, 32'h4000_0000, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 32'h0000_03E8, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Most negative I/Q through a folded angle.
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'h8000_8000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Tuning word changes only at the packet boundary.
    applyStimulus(1'b1, 32'h0001_0002, 1'b1, 1'b1, 32'h0001_0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0003_0004, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0005_0006, 1'b0, 1'b1, 32'h0100_0000, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 32'h0007_0008, k == 2, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'h0009_000A, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Clear coincident with an accepted beat at phase 0x12340000.
    applyStimulus(1'b1, 32'h0000_0001, 1'b1, 1'b1, 32'h1234_0000, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_0002, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_0003, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Continuous stream with a 5-cycle downstream stall.
    for (int k = 0; k < 16; k++)
      applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 32'd0, 1'b0, !(k >= 6 && k < 11), 1'b0);
    idle(3);

    // Reset with both output and skid registers occupied.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'h0011_0022, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Fully random traffic, loads, clears and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      d = $urandom;
      if ($urandom_range(0, 7) == 0) d[15:0] = 16'h8000;
      if ($urandom_range(0, 7) == 0) d[31:16] = 16'h8000;
      applyStimulus($urandom_range(0, 3) != 0, d, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 31) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
    end
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
